hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: load-use and HI/LO stalls, branch flushes, mult/div busy tracking
module hazard_ctrl #(
  parameter int MULDIV_LAT = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead_EX,
  input  logic [4:0]  Rt_EX,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UsesRt_ID,
  input  logic        HiLoRead_ID,
  input  logic        MulDiv_EX,
  input  logic        BranchTaken_MEM,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic        MulDivBusy,
  output logic [15:0] StallCycles
);

  localparam logic [5:0] LAT = 6'(MULDIV_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [5:0] md_cnt;
  logic [5:0] md_cnt_next;
  logic       md_start;
  logic       lu;
  logic       hl;
  logic       stall;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      md_cnt      <= 6'd0;
      StallCycles <= 16'd0;
    end else begin
      md_cnt <= md_cnt_next;
      if (stall && StallCycles != 16'hFFFF)
        StallCycles <= StallCycles + 16'd1;
    end
  end

  always_comb begin
    state       = (md_cnt != 6'd0) ? BUSY : IDLE;
    md_start    = MulDiv_EX && !BranchTaken_MEM;
    md_cnt_next = md_cnt;
    // A new mult/div restarts the count even while the unit is still busy
    if (md_start)
      md_cnt_next = LAT;
    else if (state == BUSY)
      md_cnt_next = md_cnt - 6'd1;

    lu = MemRead_EX && (Rt_EX != 5'd0) &&
         ((Rt_EX == Rs_ID) || (UsesRt_ID && (Rt_EX == Rt_ID)));
    hl = HiLoRead_ID && ((state == BUSY) || md_start);
    stall = (lu || hl) && !BranchTaken_MEM;

    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    if (Rst) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else if (BranchTaken_MEM) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (stall) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  assign MulDivBusy = (state == BUSY);

endmodule
